// File: rtl/fractal_pixel_sink_if.sv
// Result/frame-buffer bundle between the fractal engine, the pixel sink and
// the frame-buffer RAM port.
//  Producer side : data_available, x_coord, y_coord, iter_count, is_in_set -> sink
//                  data_read (one-cycle acknowledge)                       <- sink
//  RAM side      : fb_addr, fb_data, fb_we                                 <- sink
//                  fb_wait (stall, write accepted when fb_we & ~fb_wait)   -> sink
//  Status        : frame_done (pulse), coord_err (sticky)                  <- sink
// The sink connects through the slave modport; the environment (producer,
// RAM model, status observer) uses the master modport.
interface fractal_pixel_sink_if #(
  parameter int ADDR_W = 19
);
  logic              data_available;
  logic [9:0]        x_coord;
  logic [9:0]        y_coord;
  logic [10:0]       iter_count;
  logic              is_in_set;
  logic              data_read;
  logic [ADDR_W-1:0] fb_addr;
  logic [11:0]       fb_data;
  logic              fb_we;
  logic              fb_wait;
  logic              frame_done;
  logic              coord_err;

  modport slave (
    input  data_available, x_coord, y_coord, iter_count, is_in_set, fb_wait,
    output data_read, fb_addr, fb_data, fb_we, frame_done, coord_err
  );

  modport master (
    output data_available, x_coord, y_coord, iter_count, is_in_set, fb_wait,
    input  data_read, fb_addr, fb_data, fb_we, frame_done, coord_err
  );
endinterface

// File: rtl/fractal_pixel_sink.sv
// Consumer end of the fractal engine result handshake.
// Each accepted {x, y, iter, in_set} result is buffered in a small FIFO, then
// passes through two write stages: S1 holds the popped result, S2 holds the
// computed frame-buffer address/colour and drives fb_we until the RAM accepts.
// Written pixels are counted; frame_done pulses the cycle after the last
// pixel of a frame is accepted. Out-of-range coordinates are dropped and
// flagged on the sticky coord_err.
// Ports:
//  clock    in  system clock, rising edge
//  reset_n  in  asynchronous active-low reset
//  bus      fractal_pixel_sink_if.slave (handshake, RAM port, status)
module fractal_pixel_sink #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  fractal_pixel_sink_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(H_RES * V_RES - 1);

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [10:0] iter;
    logic        in_set;
  } result_t;

  typedef enum logic [1:0] {IDLE, ACK, HOLD} rx_state_e;

  rx_state_e         rx_state_q, rx_state_d;
  result_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              s1_valid_q, s1_valid_d;
  result_t           s1_q, s1_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [11:0]       fb_data_q, fb_data_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              coord_err_q, coord_err_d;

  result_t           rx_word;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              s2_accept, s2_free, s1_advance, s1_free;
  logic              s1_in_range;
  logic [ADDR_W-1:0] s1_addr;
  logic [11:0]       s1_colour;

  assign rx_word    = '{x: bus.x_coord, y: bus.y_coord,
                        iter: bus.iter_count, in_set: bus.is_in_set};
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Receive FSM: capture on the IDLE edge, acknowledge in ACK, then give the
  // producer one HOLD cycle to drop data_available. The full test uses the
  // registered occupancy, so a pop in the same cycle does not free a slot
  // until IDLE re-evaluates on the next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rx_state_d = rx_state_q;
    push       = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (bus.data_available && !fifo_full) begin
          push       = 1'b1;
          rx_state_d = ACK;
        end
      end
      ACK:     rx_state_d = HOLD;
      HOLD:    rx_state_d = IDLE;
      default: rx_state_d = IDLE;
    endcase
  end

  // Stage handshakes: S2 frees when it is empty or its write is taken this
  // cycle; S1 moves into S2 whenever S2 frees, and the FIFO refills S1 in the
  // same cycle, giving one write per cycle while fb_wait is low.
  assign s2_accept  = fb_we_q && !bus.fb_wait;
  assign s2_free    = !fb_we_q || s2_accept;
  assign s1_advance = s1_valid_q && s2_free;
  assign s1_free    = !s1_valid_q || s1_advance;
  assign pop        = !fifo_empty && s1_free;

  // Address arithmetic modulo 2**ADDR_W gives the same low bits as the
  // full-width y*H_RES+x truncated to ADDR_W.
  assign s1_in_range = ({22'd0, s1_q.x} < 32'(H_RES)) && ({22'd0, s1_q.y} < 32'(V_RES));
  assign s1_addr     = ADDR_W'(s1_q.y) * ADDR_W'(H_RES) + ADDR_W'(s1_q.x);
  // Escaped points force the blue LSB high so they are never black.
  assign s1_colour   = s1_q.in_set ? 12'h000
                                   : {s1_q.iter[3:0], s1_q.iter[7:4], s1_q.iter[10:8], 1'b1};

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    s1_valid_d   = s1_valid_q;
    s1_d         = s1_q;
    fb_we_d      = fb_we_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    coord_err_d  = coord_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    if (pop) begin
      s1_d       = fifo_mem[rd_ptr_q];
      s1_valid_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (s2_accept) fb_we_d = 1'b0;
    if (s1_advance) begin
      if (s1_in_range) begin
        fb_we_d   = 1'b1;
        fb_addr_d = s1_addr;
        fb_data_d = s1_colour;
      end else begin
        coord_err_d = 1'b1;
      end
    end

    if (s2_accept) begin
      if (pix_cnt_q == LAST_PIXEL) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count are reset,
  // so stale entries are never visible and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_word;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q   <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      coord_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      coord_err_q  <= coord_err_d;
    end
  end

  assign bus.data_read  = (rx_state_q == ACK);
  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.coord_err  = coord_err_q;

endmodule

// File: tb/tb_fractal_pixel_sink.sv
// Directed bench for fractal_pixel_sink: a 640x480 instance for the main
// scenarios and a 4x2 instance for frame wrap. One producer drives either
// instance, selected by sel_small. Inputs change 1 time unit after the rising
// edge; accepted writes and pulses are logged on the falling edge.
module tb_fractal_pixel_sink;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_avail = 1'b0;
  logic [9:0]  p_x = '0;
  logic [9:0]  p_y = '0;
  logic [10:0] p_iter = '0;
  logic        p_set = 1'b0;
  logic        fb_wait_m = 1'b0;
  logic        sel_small = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int s_fd_count = 0;
  int s_fd_cyc = 0;

  typedef struct {
    logic [18:0] addr;
    logic [11:0] data;
  } wr_t;

  wr_t        wr_log[$];
  logic [2:0] s_log[$];
  int         s_wr_cyc[$];

  fractal_pixel_sink_if #(.ADDR_W(19)) bus ();
  fractal_pixel_sink_if #(.ADDR_W(3))  sbus ();

  assign bus.data_available  = p_avail && !sel_small;
  assign bus.x_coord         = p_x;
  assign bus.y_coord         = p_y;
  assign bus.iter_count      = p_iter;
  assign bus.is_in_set       = p_set;
  assign bus.fb_wait         = fb_wait_m;
  assign sbus.data_available = p_avail && sel_small;
  assign sbus.x_coord        = p_x;
  assign sbus.y_coord        = p_y;
  assign sbus.iter_count     = p_iter;
  assign sbus.is_in_set      = p_set;
  assign sbus.fb_wait        = 1'b0;

  fractal_pixel_sink #(.H_RES(640), .V_RES(480), .ADDR_W(19), .FIFO_DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  fractal_pixel_sink #(.H_RES(4), .V_RES(2), .ADDR_W(3), .FIFO_DEPTH(4)) dut_s (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sbus.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.fb_we && !bus.fb_wait) wr_log.push_back('{bus.fb_addr, bus.fb_data});
    if (bus.data_read) rd_pulses <= rd_pulses + 1;
    if (sbus.fb_we && !sbus.fb_wait) begin
      s_log.push_back(sbus.fb_addr);
      s_wr_cyc.push_back(cyc);
    end
    if (sbus.frame_done) begin
      s_fd_count <= s_fd_count + 1;
      s_fd_cyc   <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one result; keep data_available high for 'hold' cycles after the
  // acknowledge is seen. On timeout data_available is left high.
  task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [10:0] it,
                      input logic s, input int hold, input int budget, output bit ok);
    p_x = x; p_y = y; p_iter = it; p_set = s; p_avail = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (sel_small ? sbus.data_read : bus.data_read) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (hold) tick();
      p_avail = 1'b0;
    end
  endtask

  task automatic expect_write(input string tag, input logic [18:0] a, input logic [11:0] d);
    wr_t w;
    for (int c = 0; c < 30 && wr_log.size() == 0; c++) tick();
    check({tag, "_present"}, (wr_log.size() > 0) ? 1 : 0, 1);
    if (wr_log.size() > 0) begin
      w = wr_log.pop_front();
      check({tag, "_addr"}, 32'(w.addr), 32'(a));
      check({tag, "_data"}, 32'(w.data), 32'(d));
    end
  endtask

  // Stall vectors: addr = y*640+x, colour = {iter[3:0], iter[7:4], iter[10:8], 1}.
  logic [9:0]  t3_x [7] = '{10'd10, 10'd11, 10'd12, 10'd13, 10'd14, 10'd15, 10'd16};
  logic [9:0]  t3_y [7] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7};
  logic [10:0] t3_it[7] = '{11'h000, 11'h001, 11'h0F0, 11'h123, 11'h456, 11'h789, 11'h2A6};
  logic [18:0] t3_a [7] = '{19'd650, 19'd1291, 19'd1932, 19'd2573, 19'd3214, 19'd3855, 19'd4496};
  logic [11:0] t3_d [7] = '{12'h001, 12'h101, 12'h0F1, 12'h323, 12'h659, 12'h98F, 12'h6A5};

  initial begin
    bit ok;
    int base;

    // Reset state
    repeat (2) tick();
    check("rst_data_read", bus.data_read, 0);
    check("rst_fb_we", bus.fb_we, 0);
    check("rst_fb_addr", 32'(bus.fb_addr), 0);
    check("rst_fb_data", 32'(bus.fb_data), 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_coord_err", bus.coord_err, 0);
    check("rst_s_fb_we", sbus.fb_we, 0);
    reset_n = 1'b1;
    tick();

    // 1: x=3,y=2,iter=5 -> addr 2*640+3=1283, colour R=5 G=0 B={000,1} = 12'h501
    p_x = 10'd3; p_y = 10'd2; p_iter = 11'd5; p_set = 1'b0; p_avail = 1'b1;
    tick();  // capture edge just passed
    check("t1_read_pulse", bus.data_read, 1);
    check("t1_we_early0", bus.fb_we, 0);
    tick();
    p_avail = 1'b0;
    check("t1_read_one_cycle", bus.data_read, 0);
    check("t1_we_early1", bus.fb_we, 0);
    tick();  // two edges after capture
    check("t1_we", bus.fb_we, 1);
    check("t1_addr", 32'(bus.fb_addr), 32'd1283);
    check("t1_data", 32'(bus.fb_data), 32'h501);
    tick();
    check("t1_we_drop", bus.fb_we, 0);
    expect_write("t1_log", 19'd1283, 12'h501);

    // 2: in-set point at origin -> black at address 0; data_available held
    //    through ACK and HOLD must still give a single acknowledge
    base = rd_pulses;
    send(10'd0, 10'd0, 11'h3FF, 1'b1, 2, 20, ok);
    check("t2_accept", ok, 1);
    repeat (6) tick();
    check("t2_single_pulse", rd_pulses - base, 1);
    expect_write("t2_wr", 19'd0, 12'h000);

    // 3: RAM stalled: S2, S1 and the 4-entry FIFO fill (6 results), the 7th
    //    is refused; release and all 7 drain in order
    fb_wait_m = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(t3_x[i], t3_y[i], t3_it[i], 1'b0, 1, 20, ok);
      check($sformatf("t3_accept%0d", i), ok, 1);
    end
    base = rd_pulses;
    send(t3_x[6], t3_y[6], t3_it[6], 1'b0, 1, 12, ok);
    check("t3_backpressure", ok, 0);
    check("t3_no_read", rd_pulses - base, 0);
    check("t3_we_held", bus.fb_we, 1);
    check("t3_addr_held", 32'(bus.fb_addr), 32'd650);
    check("t3_no_write", wr_log.size(), 0);
    fb_wait_m = 1'b0;
    send(t3_x[6], t3_y[6], t3_it[6], 1'b0, 1, 20, ok);
    check("t3_accept6", ok, 1);
    for (int i = 0; i < 7; i++) expect_write($sformatf("t3_wr%0d", i), t3_a[i], t3_d[i]);
    repeat (10) tick();
    check("t3_no_dup", wr_log.size(), 0);

    // 4: x=640 and y=480 are dropped with sticky coord_err; the far corner
    //    (639,479) writes addr 307199, iter 7FF -> 12'hFFF
    send(10'd640, 10'd0, 11'd9, 1'b0, 1, 20, ok);
    repeat (8) tick();
    check("t4_x_dropped", wr_log.size(), 0);
    check("t4_coord_err", bus.coord_err, 1);
    send(10'd0, 10'd480, 11'd9, 1'b0, 1, 20, ok);
    repeat (8) tick();
    check("t4_y_dropped", wr_log.size(), 0);
    send(10'd639, 10'd479, 11'h7FF, 1'b0, 1, 20, ok);
    expect_write("t4_corner", 19'd307199, 12'hFFF);
    check("t4_err_sticky", bus.coord_err, 1);

    // 5: 4x2 frame: 8 pixels then frame_done one cycle after the 8th write;
    //    9th pixel restarts at address 0
    sel_small = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(10'(i % 4), 10'((i / 4) % 2), 11'(i), 1'b0, 1, 20, ok);
      check($sformatf("t5_accept%0d", i), ok, 1);
    end
    repeat (6) tick();
    check("t5_writes", s_log.size(), 9);
    check("t5_frame_pulses", s_fd_count, 1);
    if (s_log.size() == 9) begin
      for (int i = 0; i < 9; i++) check($sformatf("t5_addr%0d", i), 32'(s_log[i]), i % 8);
      check("t5_fd_gap", s_fd_cyc - s_wr_cyc[7], 1);
    end
    send(10'd4, 10'd1, 11'd0, 1'b0, 1, 20, ok);
    repeat (8) tick();
    check("t5_s_coord_err", sbus.coord_err, 1);
    check("t5_s_dropped", s_log.size(), 9);
    sel_small = 1'b0;

    // 6: reset with a write pending and 3 results buffered behind it
    fb_wait_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(t3_x[i], t3_y[i], t3_it[i], 1'b0, 1, 20, ok);
      check($sformatf("t6_accept%0d", i), ok, 1);
    end
    check("t6_we_pending", bus.fb_we, 1);
    reset_n = 1'b0;
    #1;
    check("t6_we_cleared", bus.fb_we, 0);
    check("t6_addr_cleared", 32'(bus.fb_addr), 0);
    check("t6_data_cleared", 32'(bus.fb_data), 0);
    check("t6_err_cleared", bus.coord_err, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    fb_wait_m = 1'b0;
    repeat (10) tick();
    check("t6_no_stale", wr_log.size(), 0);
    // x=1,y=1,iter=00A -> addr 641, colour R=A G=0 B=1
    send(10'd1, 10'd1, 11'h00A, 1'b0, 1, 20, ok);
    check("t6_accept_after", ok, 1);
    expect_write("t6_wr", 19'd641, 12'hA01);
    repeat (5) tick();
    check("t6_no_extra", wr_log.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
